// File: rtl/snn_pkg.sv
// Shared types and default sizes for the SNN timestep scheduler.
package snn_pkg;

    localparam int SNN_NUM_INPUTS  = 64;
    localparam int SNN_NUM_NEURONS = 10;
    localparam int SNN_WEIGHT_W    = 8;
    localparam int SNN_TS_W        = 8;

    typedef enum logic [1:0] {
        NU_NOP       = 2'd0,
        NU_CLEAR     = 2'd1,
        NU_ACCUM     = 2'd2,
        NU_LEAK_FIRE = 2'd3
    } nu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT_SPK,
        S_SCAN,
        S_ACCUM,
        S_LEAK,
        S_EMIT
    } sched_state_t;

endpackage

// File: rtl/snn_timestep_scheduler.sv
// Sequences CLEAR, spike scan with weight streaming, LEAK_FIRE and EMIT for N timesteps per run.
// Optional macro SNN_SCHED_ABORT_EN adds the abort_i input that drops a run back to IDLE.
module snn_timestep_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS  = SNN_NUM_INPUTS,
    parameter int NUM_NEURONS = SNN_NUM_NEURONS,
    parameter int WEIGHT_W    = SNN_WEIGHT_W,
    parameter int TS_W        = SNN_TS_W,
    parameter int ADDR_W      = $clog2(NUM_INPUTS * NUM_NEURONS)
) (
    input  logic                           wb_clk_i,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [TS_W-1:0]                num_ts_i,
`ifdef SNN_SCHED_ABORT_EN
    input  logic                           abort_i,
`endif
    output logic                           busy_o,
    output logic                           done_o,
    input  logic                           spike_valid_i,
    output logic                           spike_ready_o,
    input  logic [NUM_INPUTS-1:0]          spike_vec_i,
    output logic                           w_rd_en_o,
    output logic [ADDR_W-1:0]              w_addr_o,
    input  logic [WEIGHT_W-1:0]            w_data_i,
    output nu_op_t                         nu_op_o,
    output logic [$clog2(NUM_NEURONS)-1:0] nu_idx_o,
    output logic [WEIGHT_W-1:0]            nu_weight_o,
    input  logic                           fired_i,
    output logic                           out_valid_o,
    output logic [NUM_NEURONS-1:0]         out_spikes_o
);

    localparam int IN_W  = $clog2(NUM_INPUTS);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int K_W   = $clog2(NUM_NEURONS + 1);
    localparam logic [K_W-1:0]  K_LAST    = K_W'(NUM_NEURONS);
    localparam logic [K_W-1:0]  K_CLR_END = K_W'(NUM_NEURONS - 1);
    localparam logic [IN_W-1:0] IN_LAST   = IN_W'(NUM_INPUTS - 1);

    sched_state_t           r_state, w_state_next;
    logic [K_W-1:0]         r_k;
    logic [IN_W-1:0]        r_in_idx;
    logic [NUM_INPUTS-1:0]  r_vec;
    logic [TS_W-1:0]        r_ts_num, r_ts_cnt;
    logic [NUM_NEURONS-1:0] r_shadow, r_out_spikes, w_shadow_next;
    logic                   r_done;
    logic                   w_abort, w_bit, w_last_in, w_k_end, w_last_ts, w_capture;
    logic [IDX_W-1:0]       w_cur_k, w_prev_k;
    logic [ADDR_W-1:0]      w_rd_addr;

`ifdef SNN_SCHED_ABORT_EN
    assign w_abort = abort_i && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_bit     = r_vec[r_in_idx];
    assign w_last_in = (r_in_idx == IN_LAST);
    assign w_k_end   = (r_k == K_LAST);
    assign w_last_ts = ((r_ts_cnt + 1'b1) == r_ts_num);
    assign w_cur_k   = IDX_W'(r_k);
    assign w_prev_k  = IDX_W'(r_k - 1'b1);
    assign w_rd_addr = ADDR_W'(32'(r_in_idx) * NUM_NEURONS + 32'(r_k));
    assign w_capture = (r_state == S_LEAK) && (r_k != '0);

    // fired_i lags its LEAK_FIRE by one cycle, so it lands in the bit of the previous command
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_shadow
        assign w_shadow_next[gi] = (w_capture && (w_prev_k == IDX_W'(gi))) ? fired_i : r_shadow[gi];
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (start_i) w_state_next = S_CLR;
                S_CLR:      if (r_k == K_CLR_END) w_state_next = S_WAIT_SPK;
                S_WAIT_SPK: if (spike_valid_i) w_state_next = S_SCAN;
                S_SCAN: begin
                    if (w_bit)          w_state_next = S_ACCUM;
                    else if (w_last_in) w_state_next = S_LEAK;
                end
                S_ACCUM:    if (w_k_end) w_state_next = w_last_in ? S_LEAK : S_SCAN;
                S_LEAK:     if (w_k_end) w_state_next = S_EMIT;
                S_EMIT:     w_state_next = w_last_ts ? S_IDLE : S_WAIT_SPK;
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    // ACCUM cycle k reads neuron k's weight; cycle k+1 forwards it, the last cycle only drains
    always_comb begin
        busy_o        = (r_state != S_IDLE);
        spike_ready_o = (r_state == S_WAIT_SPK) && !w_abort;
        out_valid_o   = (r_state == S_EMIT) && !w_abort;
        w_rd_en_o     = 1'b0;
        w_addr_o      = '0;
        nu_op_o       = NU_NOP;
        nu_idx_o      = '0;
        nu_weight_o   = '0;
        if (!w_abort) begin
            case (r_state)
                S_CLR: begin
                    nu_op_o  = NU_CLEAR;
                    nu_idx_o = w_cur_k;
                end
                S_ACCUM: begin
                    if (!w_k_end) begin
                        w_rd_en_o = 1'b1;
                        w_addr_o  = w_rd_addr;
                    end
                    if (r_k != '0) begin
                        nu_op_o     = NU_ACCUM;
                        nu_idx_o    = w_prev_k;
                        nu_weight_o = w_data_i;
                    end
                end
                S_LEAK: begin
                    if (!w_k_end) begin
                        nu_op_o  = NU_LEAK_FIRE;
                        nu_idx_o = w_cur_k;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o       = r_done;
    assign out_spikes_o = r_out_spikes;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_in_idx     <= '0;
            r_vec        <= '0;
            r_ts_num     <= '0;
            r_ts_cnt     <= '0;
            r_shadow     <= '0;
            r_out_spikes <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_k <= '0;
            end else if (r_state == S_CLR || r_state == S_ACCUM || r_state == S_LEAK) begin
                r_k <= r_k + 1'b1;
            end
            if (r_state == S_IDLE && start_i) begin
                r_ts_num <= (num_ts_i == '0) ? TS_W'(1) : num_ts_i;
                r_ts_cnt <= '0;
            end
            if (r_state == S_WAIT_SPK && spike_valid_i && !w_abort) begin
                r_vec    <= spike_vec_i;
                r_in_idx <= '0;
            end
            if (((r_state == S_SCAN && !w_bit) || (r_state == S_ACCUM && w_k_end)) && !w_last_in) begin
                r_in_idx <= r_in_idx + 1'b1;
            end
            if (r_state == S_EMIT && !w_abort) begin
                r_ts_cnt <= r_ts_cnt + 1'b1;
            end
            r_shadow <= w_shadow_next;
            if (r_state == S_LEAK && w_k_end && !w_abort) begin
                r_out_spikes <= w_shadow_next;
            end
            r_done <= (r_state == S_EMIT) && w_last_ts && !w_abort;
        end
    end

endmodule
